// File: rtl/ifid_reg.sv
// Fetch-to-decode pipeline register of the RV32i core.
// Also holds the sequential-PC adder whose result feeds the PC register.

module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Carry-out is dropped, so the sum wraps modulo 2^32.
  assign sum = a + b;
endmodule

module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_INC    = 32'h0000_0004
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Flush_D,
  input  logic        Stall_En,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus_4_D
);

  adder32 u_pc_adder (
    .a   (PC_F),
    .b   (PC_INC),
    .sum (PC_Plus_4_F)
  );

  // Reset clears the instruction to all-zero, not NOP; downstream treats zero as a bubble.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      Instr_D     <= 32'h0;
      PC_D        <= 32'h0;
      PC_Plus_4_D <= 32'h0;
    end else if (Flush_D) begin
      Instr_D     <= NOP_INSTR;
      PC_D        <= 32'h0;
      PC_Plus_4_D <= 32'h0;
    end else if (!Stall_En) begin
      Instr_D     <= Instr_F;
      PC_D        <= PC_F;
      PC_Plus_4_D <= PC_Plus_4_F;
    end
  end

endmodule

// File: tb/tb_ifid_reg.sv
// Self-checking bench for ifid_reg: directed cases plus a randomized run
// compared against a rule-level model of the decode-stage contents.

module tb_ifid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Flush_D, Stall_En;
  logic [31:0] Instr_F, PC_F;
  logic [31:0] PC_Plus_4_F, Instr_D, PC_D, PC_Plus_4_D;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } dstage_t;

  dstage_t exp_d;
  int errors = 0;
  int checks = 0;

  ifid_reg dut (
    .CLK         (CLK),
    .RST         (RST),
    .Flush_D     (Flush_D),
    .Stall_En    (Stall_En),
    .Instr_F     (Instr_F),
    .PC_F        (PC_F),
    .PC_Plus_4_F (PC_Plus_4_F),
    .Instr_D     (Instr_D),
    .PC_D        (PC_D),
    .PC_Plus_4_D (PC_Plus_4_D)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag);
    check({tag, ".instr"}, Instr_D, exp_d.instr);
    check({tag, ".pc"}, PC_D, exp_d.pc);
    check({tag, ".pc4"}, PC_Plus_4_D, exp_d.pc4);
  endtask

  // Apply inputs, check the fetch adder, clock once, update the model, check decode outputs.
  task automatic step(input string tag, input logic flush, input logic stall,
                      input logic [31:0] instr, input logic [31:0] pc);
    Flush_D  = flush;
    Stall_En = stall;
    Instr_F  = instr;
    PC_F     = pc;
    #1;
    check({tag, ".adder"}, PC_Plus_4_F, pc + 32'd4);
    @(posedge CLK);
    #1;
    if (flush)       exp_d = '{NOP, 32'h0, 32'h0};
    else if (!stall) exp_d = '{instr, pc, pc + 32'd4};
    check_d(tag);
  endtask

  initial begin
    RST = 1'b0; Flush_D = 1'b0; Stall_En = 1'b0; Instr_F = 32'h0; PC_F = 32'h0;
    exp_d = '{32'h0, 32'h0, 32'h0};
    #2;
    check_d("reset_init");
    RST = 1'b1;

    step("normal", 1'b0, 1'b0, 32'h0050_0093, 32'h100);

    // Stall: capture 0x200, then hold for three edges while inputs change.
    step("stall_load", 1'b0, 1'b0, 32'h1234_5678, 32'h200);
    for (int i = 0; i < 3; i++)
      step($sformatf("stall_hold%0d", i), 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h204);
    step("stall_release", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h204);

    step("flush", 1'b1, 1'b0, 32'hCAFE_F00D, 32'h300);
    step("refill", 1'b0, 1'b0, 32'h0010_0113, 32'h304);
    step("flush_stall", 1'b1, 1'b1, 32'hCAFE_F00D, 32'h308);

    step("wrap", 1'b0, 1'b0, 32'h0000_0033, 32'hFFFF_FFFC);
    check("wrap.explicit_pc4", PC_Plus_4_D, 32'h0);

    for (int i = 0; i < 8; i++)
      step($sformatf("stream%0d", i), 1'b0, 1'b0, 32'h0000_0013 + (i << 7), i * 4);

    // Asynchronous reset mid-cycle with nonzero outputs held.
    RST = 1'b0;
    #1;
    exp_d = '{32'h0, 32'h0, 32'h0};
    check_d("reset_async");
    check("reset_async.adder", PC_Plus_4_F, PC_F + 32'd4);
    #2;
    RST = 1'b1;
    step("after_reset", 1'b0, 1'b0, 32'h00A0_0513, 32'h400);

    for (int i = 0; i < 60; i++) begin
      logic        f, s;
      logic [31:0] ins, pc;
      f   = ($urandom_range(7) == 0);
      s   = ($urandom_range(3) == 0);
      ins = $urandom;
      pc  = {$urandom} & 32'hFFFF_FFFC;
      step($sformatf("rand%0d", i), f, s, ins, pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_reg.md
# ifid_reg

Fetch-to-decode pipeline boundary of the RV32i pipelined core. Computes the sequential next PC (PC + 4) combinationally for the program counter, then registers the fetched instruction, PC and PC + 4 into the decode stage. Supports stall (hold) and flush (bubble insertion) from hazard control.

## Interface

Parameters:
- `NOP_INSTR`, default 32'h00000013: encoding inserted on flush (ADDI x0, x0, 0).
- `PC_INC`, default 32'h4: increment applied by the internal PC adder.

Ports:
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST` input, 1 bit: reset is asynchronous and active-low. `RST`=0 clears state immediately, independent of `CLK`.
- `Flush_D` input, 1 bit: replace decode-stage contents with a bubble at the next edge.
- `Stall_En` input, 1 bit: hold decode-stage contents at the next edge.
- `Instr_F` input, 32 bits: instruction read from instruction memory at `PC_F`.
- `PC_F` input, 32 bits: current fetch PC.
- `PC_Plus_4_F` output, 32 bits: combinational `PC_F` + `PC_INC`; feeds the PC register input.
- `Instr_D` output, 32 bits: registered instruction for decode.
- `PC_D` output, 32 bits: registered PC for decode.
- `PC_Plus_4_D` output, 32 bits: registered PC + 4 for decode (link address).

## Operation

- Adder:
  - `PC_Plus_4_F` = (`PC_F` + `PC_INC`) mod 2^32.
  - Unsigned, carry-out discarded; 32'hFFFFFFFC + 4 = 32'h00000000.
  - Purely combinational. Unaffected by reset, stall or flush.
- Register update priority, highest first:
  1. Reset (`RST`=0): `Instr_D`, `PC_D`, `PC_Plus_4_D` are all 32'h0.
  2. Flush (`Flush_D`=1): `Instr_D` ← `NOP_INSTR`; `PC_D` ← 0; `PC_Plus_4_D` ← 0.
  3. Stall (`Stall_En`=1, no flush): all three registers hold their values.
  4. Otherwise: `Instr_D` ← `Instr_F`; `PC_D` ← `PC_F`; `PC_Plus_4_D` ← `PC_Plus_4_F`.
- Flush and stall asserted together: flush wins.
- The reset value of `Instr_D` is 32'h0, not the NOP encoding. Downstream logic treats all-zero as a bubble during reset.
- No internal FSM. The block is three 32-bit registers plus one 32-bit adder. The adder must be written as a reusable 32-bit adder submodule instantiated inside the block.

## Timing

- `PC_Plus_4_F` is valid in the same cycle `PC_F` is valid (zero latency).
- Decode outputs have 1-cycle latency: values present before rising edge N appear on `*_D` after edge N.
- Reset assertion: outputs go to 0 asynchronously, with no clock edge required. Assertion mid-cycle discards any pending capture.
- Reset release: the first capture, flush or stall takes effect at the first rising edge with `RST`=1.
- `Flush_D` and `Stall_En` are sampled only at the rising edge. Each is a one-edge effect per cycle asserted.
- Stall held for K edges: outputs remain unchanged for K edges. Normal capture resumes at the first edge with `Stall_En`=0.

## Test plan

- Reset: drive `RST`=0 mid-cycle with nonzero outputs. All `*_D` read 0 before the next edge. `PC_Plus_4_F` still equals `PC_F`+4.
- Normal flow: `PC_F`=0x100, `Instr_F`=0x00500093. After one edge: `Instr_D`=0x00500093, `PC_D`=0x100, `PC_Plus_4_D`=0x104.
- Stall: load `PC_F`=0x200, then set `Stall_En`=1 and change to `PC_F`=0x204, `Instr_F`=0xDEADBEEF for 3 edges. Outputs stay at `PC_D`=0x200 and the old instruction. After release, the next edge captures 0x204.
- Flush, including flush with stall: `Flush_D`=1 (with `Stall_En`=1 in a second pass). After the edge: `Instr_D`=0x00000013, `PC_D`=0, `PC_Plus_4_D`=0.
- Adder wrap: `PC_F`=0xFFFFFFFC gives `PC_Plus_4_F`=0x00000000. After one edge, `PC_Plus_4_D`=0.
- Stream of 8 sequential PCs 0x0…0x1C: each edge, `PC_D` and `PC_Plus_4_D` track the previous cycle's inputs exactly.
